// File: rtl/pen_locator.sv
// Light-pen position locator: syncs the pen, lag-aligns the scan coordinates, confirms a
// position over several frames and reports it with a valid/ready handshake. Optional PEN_DIAG_EN.
module pen_locator #(
  parameter int unsigned PEN_DLY   = 2,
  parameter int unsigned CONFIRM_N = 2,
  parameter int unsigned MISS_MAX  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pen_in,
  input  logic [2:0] scan_row,
  input  logic [2:0] scan_col,
  input  logic       probe_en,
  input  logic       frame_start,
  input  logic       pos_ready,
  output logic       pos_valid,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic       lost,
  output logic       overrun,
  output logic [7:0] diag_hits
);
  localparam logic [2:0] LP_CONF = 3'(CONFIRM_N);
  localparam logic [2:0] LP_MISS = 3'(MISS_MAX);

  typedef enum logic {SEARCH, TRACK} state_t;
  state_t r_state;

  logic       r_sync1, r_sync2, r_pen_prev;
  logic       r_armed;
  logic       r_hit_v;
  logic [2:0] r_hit_row, r_hit_col;
  logic [2:0] r_cand_row, r_cand_col;
  logic [2:0] r_conf, r_miss;
  logic       r_last_v;
  logic [2:0] r_last_row, r_last_col;

  logic [6:0] w_raw, w_dly;
  logic       w_edge, w_cap, w_close, w_same, w_result, w_load, w_accept;
  logic [2:0] w_conf_nxt, w_miss_nxt;

  assign w_raw = {probe_en, scan_row, scan_col};

  // Scan coordinates are delayed so they line up with the pen's optical lag.
  generate
    if (PEN_DLY == 0) begin : g_nodly
      assign w_dly = w_raw;
    end else begin : g_dly
      logic [6:0] r_pipe [PEN_DLY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < PEN_DLY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_raw;
          for (int unsigned i = 1; i < PEN_DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_dly = r_pipe[PEN_DLY-1];
    end
  endgenerate

  assign w_edge     = r_sync2 & ~r_pen_prev;
  assign w_cap      = w_edge & w_dly[6];
  assign w_close    = frame_start & r_armed;
  assign w_same     = (r_state == TRACK) && (r_hit_row == r_cand_row) && (r_hit_col == r_cand_col);
  assign w_conf_nxt = w_same ? ((r_conf == LP_CONF) ? r_conf : r_conf + 3'd1) : 3'd1;
  assign w_miss_nxt = r_miss + 3'd1;
  assign w_result   = w_close & r_hit_v & (w_conf_nxt == LP_CONF) &
                      (~r_last_v | (r_hit_row != r_last_row) | (r_hit_col != r_last_col));
  assign w_load     = w_result & (~pos_valid | pos_ready);
  assign w_accept   = pos_valid & pos_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEARCH;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_pen_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_hit_v    <= 1'b0;
      r_hit_row  <= '0;
      r_hit_col  <= '0;
      r_cand_row <= '0;
      r_cand_col <= '0;
      r_conf     <= '0;
      r_miss     <= '0;
      r_last_v   <= 1'b0;
      r_last_row <= '0;
      r_last_col <= '0;
      pos_valid  <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      lost       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_sync1    <= pen_in;
      r_sync2    <= r_sync1;
      r_pen_prev <= r_sync2;
      lost       <= 1'b0;

      // An edge on the frame_start cycle opens the new frame's hit slot.
      if (frame_start) begin
        r_armed <= 1'b1;
        r_hit_v <= w_cap;
        if (w_cap) {r_hit_row, r_hit_col} <= w_dly[5:0];
      end else if (w_cap && !r_hit_v) begin
        r_hit_v <= 1'b1;
        {r_hit_row, r_hit_col} <= w_dly[5:0];
      end

      if (w_close) begin
        if (r_hit_v) begin
          r_state    <= TRACK;
          r_cand_row <= r_hit_row;
          r_cand_col <= r_hit_col;
          r_conf     <= w_conf_nxt;
          r_miss     <= '0;
        end else if (r_state == TRACK) begin
          if (w_miss_nxt == LP_MISS) begin
            lost     <= 1'b1;
            r_state  <= SEARCH;
            r_conf   <= '0;
            r_miss   <= '0;
            r_last_v <= 1'b0;
          end else begin
            r_miss <= w_miss_nxt;
          end
        end
      end

      if (w_result) begin
        r_last_v   <= 1'b1;
        r_last_row <= r_hit_row;
        r_last_col <= r_hit_col;
      end

      if (w_load) begin
        pos_valid <= 1'b1;
        pos_x     <= r_hit_col;
        pos_y     <= r_hit_row;
      end else if (w_accept) begin
        pos_valid <= 1'b0;
      end

      if (w_accept) overrun <= 1'b0;
      else if (w_result && pos_valid) overrun <= 1'b1;
    end
  end

`ifdef PEN_DIAG_EN
  logic [7:0] r_edge_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      diag_hits  <= '0;
    end else if (frame_start) begin
      if (w_close) diag_hits <= r_edge_cnt;
      r_edge_cnt <= {7'd0, w_edge};
    end else if (w_edge && r_edge_cnt != 8'hFF) begin
      r_edge_cnt <= r_edge_cnt + 8'd1;
    end
  end
`else
  assign diag_hits = '0;
`endif

endmodule

// File: tb/tb_pen_locator.sv
// Bench for pen_locator: directed scenarios plus randomized frames, all checked every cycle
// against a frame-level reference model.
module tb_pen_locator;
  localparam int D  = 2;
  localparam int CN = 2;
  localparam int MM = 3;
  localparam int HMAX = 4096;
`ifdef PEN_DIAG_EN
  localparam int DIAG_EXP = 3;
`else
  localparam int DIAG_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pen_in = 1'b0, probe_en = 1'b0, frame_start = 1'b0, pos_ready = 1'b0;
  logic [2:0] scan_row = '0, scan_col = '0;
  logic       pos_valid, lost, overrun;
  logic [2:0] pos_x, pos_y;
  logic [7:0] diag_hits;

  always #5 clk = ~clk;

  pen_locator #(.PEN_DLY(D), .CONFIRM_N(CN), .MISS_MAX(MM)) dut (
    .clk(clk), .rst(rst), .pen_in(pen_in), .scan_row(scan_row), .scan_col(scan_col),
    .probe_en(probe_en), .frame_start(frame_start), .pos_ready(pos_ready),
    .pos_valid(pos_valid), .pos_x(pos_x), .pos_y(pos_y), .lost(lost),
    .overrun(overrun), .diag_hits(diag_hits)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 8, r0 = 8, pv_hi = 0;

  logic       pen_h [HMAX];
  logic [6:0] crd_h [HMAX];

  // reference model state
  bit         m_track, m_armed, m_hv, m_lv;
  int         m_conf, m_miss, m_cnt;
  logic [2:0] m_cr, m_cc, m_hr, m_hc, m_lr, m_lc;
  logic       e_pv, e_lost, e_ovr;
  logic [2:0] e_px, e_py;
  int         e_diag;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic hpen(input int i);
    return (i >= r0) ? pen_h[i] : 1'b0;
  endfunction

  function automatic logic [6:0] hcrd(input int i);
    return (i >= r0) ? crd_h[i] : 7'd0;
  endfunction

  task automatic model_reset();
    m_track = 0; m_armed = 0; m_hv = 0; m_lv = 0;
    m_conf = 0; m_miss = 0; m_cnt = 0;
    {m_cr, m_cc, m_hr, m_hc, m_lr, m_lc} = '0;
    e_pv = 0; e_lost = 0; e_ovr = 0; e_px = 0; e_py = 0; e_diag = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pen_in = 0; frame_start = 0; probe_en = 0; pos_ready = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_pos_valid", 8'(pos_valid), 8'd0);
    check("rst_pos_x", 8'(pos_x), 8'd0);
    check("rst_pos_y", 8'(pos_y), 8'd0);
    check("rst_lost", 8'(lost), 8'd0);
    check("rst_overrun", 8'(overrun), 8'd0);
    check("rst_diag", diag_hits, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    r0 = cyc;
  endtask

  task automatic step(input logic pen, input logic fs, input logic pe,
                      input logic [2:0] row, input logic [2:0] col, input logic rdy);
    logic       edg, cap, res, old_pv;
    logic [6:0] d;
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX);
      $fatal(1);
    end
    @(negedge clk);
    pen_in = pen; frame_start = fs; probe_en = pe;
    scan_row = row; scan_col = col; pos_ready = rdy;
    pen_h[cyc] = pen; crd_h[cyc] = {pe, row, col};

    edg = hpen(cyc-2) && !hpen(cyc-3);
    d   = hcrd(cyc-D);
    cap = edg && d[6];
    res = 0; e_lost = 0;
    if (fs && m_armed) begin
      if (m_hv) begin
        if (m_track && m_hr == m_cr && m_hc == m_cc) m_conf = (m_conf < CN) ? m_conf + 1 : CN;
        else m_conf = 1;
        m_track = 1; m_cr = m_hr; m_cc = m_hc; m_miss = 0;
        res = (m_conf == CN) && (!m_lv || m_lr != m_cr || m_lc != m_cc);
      end else if (m_track) begin
        m_miss++;
        if (m_miss == MM) begin
          e_lost = 1; m_track = 0; m_conf = 0; m_miss = 0; m_lv = 0;
        end
      end
`ifdef PEN_DIAG_EN
      e_diag = (m_cnt > 255) ? 255 : m_cnt;
`endif
    end
    if (fs) begin
      m_armed = 1; m_cnt = int'(edg); m_hv = cap;
      if (cap) {m_hr, m_hc} = d[5:0];
    end else begin
      m_cnt += int'(edg);
      if (cap && !m_hv) begin m_hv = 1; {m_hr, m_hc} = d[5:0]; end
    end
    old_pv = e_pv;
    if (res) begin m_lv = 1; m_lr = m_cr; m_lc = m_cc; end
    if (res && (!old_pv || rdy)) begin e_pv = 1; e_px = m_cc; e_py = m_cr; end
    else if (old_pv && rdy) e_pv = 0;
    if (old_pv && rdy) e_ovr = 0;
    else if (res && old_pv) e_ovr = 1;

    @(posedge clk);
    #1;
    check("pos_valid", 8'(pos_valid), 8'(e_pv));
    check("pos_x", 8'(pos_x), 8'(e_px));
    check("pos_y", 8'(pos_y), 8'(e_py));
    check("lost", 8'(lost), 8'(e_lost));
    check("overrun", 8'(overrun), 8'(e_ovr));
    check("diag_hits", diag_hits, 8'(e_diag));
    if (pos_valid) pv_hi++;
    cyc++;
  endtask

  task automatic fs_cycle(input logic rdy);
    step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, rdy);
  endtask

  // rm: 0 ready low, 1 ready high, 2 random; hpe: probe_en at the pen hit cycle
  task automatic body(input bit hit, input logic [2:0] row, input logic [2:0] col,
                      input int extra, input int rm, input bit hpe, input int len);
    for (int k = 1; k <= len; k++) begin
      logic p, pe, rdy;
      logic [2:0] r, c;
      r  = 3'($urandom_range(0, 7));
      c  = 3'($urandom_range(0, 7));
      pe = 1'b1;
      p  = (hit && (k == 2 || k == 3)) || (extra >= 1 && (k == 6 || k == 7)) ||
           (extra >= 2 && (k == 10 || k == 11));
      if (hit && k == 2) begin r = row; c = col; pe = hpe; end
      rdy = (rm == 2) ? 1'($urandom_range(0, 1)) : (rm == 1);
      step(p, 1'b0, pe, r, c, rdy);
    end
  endtask

  initial begin
    int base;
    logic [2:0] tr, tc;
    model_reset();
    do_reset();

    // first confirmed report of (3,5)
    fs_cycle(0);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    fs_cycle(1);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    base = pv_hi;
    fs_cycle(1);
    check("first_valid", 8'(pos_valid), 8'd1);
    check("first_x", 8'(pos_x), 8'd5);
    check("first_y", 8'(pos_y), 8'd3);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    fs_cycle(1);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    fs_cycle(1);
    check("single_report", 8'(pv_hi - base), 8'd1);

    // three empty frames drop tracking
    body(0, 3'd0, 3'd0, 0, 1, 1, 15);
    fs_cycle(1);
    body(0, 3'd0, 3'd0, 0, 1, 1, 15);
    fs_cycle(1);
    body(0, 3'd0, 3'd0, 0, 1, 1, 15);
    fs_cycle(1);
    check("lost_pulse", 8'(lost), 8'd1);
    body(0, 3'd0, 3'd0, 0, 1, 1, 1);
    check("lost_one_cycle", 8'(lost), 8'd0);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    fs_cycle(1);
    check("reacquire_wait", 8'(pos_valid), 8'd0);
    body(1, 3'd3, 3'd5, 0, 1, 1, 15);
    fs_cycle(1);
    check("reacquire_report", 8'(pos_valid), 8'd1);

    // stalled consumer: (2,2) result is discarded behind (1,1)
    body(0, 3'd0, 3'd0, 0, 1, 1, 1);
    body(1, 3'd1, 3'd1, 0, 0, 1, 15);
    fs_cycle(0);
    body(1, 3'd1, 3'd1, 0, 0, 1, 15);
    fs_cycle(0);
    body(1, 3'd2, 3'd2, 0, 0, 1, 15);
    fs_cycle(0);
    body(1, 3'd2, 3'd2, 0, 0, 1, 15);
    fs_cycle(0);
    check("overrun_set", 8'(overrun), 8'd1);
    check("stall_valid", 8'(pos_valid), 8'd1);
    check("stall_x", 8'(pos_x), 8'd1);
    check("stall_y", 8'(pos_y), 8'd1);
    body(0, 3'd0, 3'd0, 0, 1, 1, 1);
    check("overrun_clear", 8'(overrun), 8'd0);

    // lag-compensated capture with extra edges in the frame
    body(1, 3'd4, 3'd6, 2, 1, 1, 14);
    fs_cycle(1);
    check("diag_three", diag_hits, 8'(DIAG_EXP));
    body(1, 3'd4, 3'd6, 2, 1, 1, 15);
    fs_cycle(1);
    check("cap_valid", 8'(pos_valid), 8'd1);
    check("cap_x", 8'(pos_x), 8'd6);
    check("cap_y", 8'(pos_y), 8'd4);

    // reset mid-frame while pos_valid is high
    body(0, 3'd0, 3'd0, 0, 0, 1, 5);
    do_reset();
    fs_cycle(0);
    check("no_lost_after_rst", 8'(lost), 8'd0);

    tr = 3'd3; tc = 3'd5;
    for (int f = 0; f < 40; f++) begin
      bit hit, hpe;
      int ex;
      hit = ($urandom_range(0, 9) < 7);
      hpe = ($urandom_range(0, 5) != 0);
      ex  = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 3))
          0: begin tr = 3'd3; tc = 3'd5; end
          1: begin tr = 3'd1; tc = 3'd1; end
          2: begin tr = 3'd2; tc = 3'd2; end
          default: begin tr = 3'($urandom_range(0, 7)); tc = 3'($urandom_range(0, 7)); end
        endcase
      end
      body(hit, tr, tc, ex, 2, hpe, ($urandom_range(0, 11) == 0) ? 5 : 15);
      if ($urandom_range(0, 11) == 0) do_reset();
      fs_cycle(1'($urandom_range(0, 1)));
    end
    body(0, 3'd0, 3'd0, 0, 1, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
